hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: drives stall/flush of the F/D, D/E, E/M, M/W registers
//  and the E-stage forwarding muxes. Detects load-use and data hazards and taken branches.

---
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard/sequencer bundle between the 5-stage pipeline datapath (master) and hazard_ctrl (slave).
// Carries register indices, busy/branch status, stall/flush/forward controls and perf counters.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D;
    logic [REG_ADDR_WIDTH-1:0] Rs2D;
    logic [REG_ADDR_WIDTH-1:0] Rs1E;
    logic [REG_ADDR_WIDTH-1:0] Rs2E;
    logic [REG_ADDR_WIDTH-1:0] RdE;
    logic [REG_ADDR_WIDTH-1:0] RdM;
    logic [REG_ADDR_WIDTH-1:0] RdW;
    logic                      ResultSrcE0;
    logic                      RegWriteM;
    logic                      RegWriteW;
    logic                      PCSrcE;
    logic                      ImemBusyF;
    logic                      DmemBusyM;

    logic                      StallF;
    logic                      StallD;
    logic                      StallE;
    logic                      StallM;
    logic                      FlushD;
    logic                      FlushE;
    logic                      FlushW;
    logic                      FetchAbort;
    logic [1:0]                ForwardAE;
    logic [1:0]                ForwardBE;
    logic                      MemTimeout;
    logic [CNT_WIDTH-1:0]      StallCycles;
    logic [CNT_WIDTH-1:0]      FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, ImemBusyF, DmemBusyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, FetchAbort,
        input  ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, ImemBusyF, DmemBusyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, FetchAbort,
        output ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush/forward control plus fetch/data-memory wait FSM with timeout.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FETCH_WAIT = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
        logic fetch_abort;
    } ctl_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 32'sd1);

    localparam ctl_t CTL_IDLE     = ctl_t'(8'b0000_0000);
    localparam ctl_t CTL_MEM_WAIT = ctl_t'(8'b1111_0010);
    localparam ctl_t CTL_RESET    = ctl_t'(8'b0000_1110);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO  = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [WAIT_W-1:0]         WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]         WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0]         WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]         WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 32'sd1);

    state_e              state_r;
    state_e              next_state_s;
    ctl_t                run_ctl_s;
    ctl_t                ctl_s;
    ctl_t                out_ctl_s;
    logic                lw_stall_s;
    logic [1:0]          fwd_a_s;
    logic [1:0]          fwd_b_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                mem_timeout_r;

    assign lw_stall_s = hz.ResultSrcE0 && (hz.RdE != REG_ZERO) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Forwarding select for both E-stage operands; the younger M result wins over W.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (hz.RegWriteM && (hz.RdM != REG_ZERO) && (hz.RdM == hz.Rs1E)) begin
            fwd_a_s = 2'b10;
        end else if (hz.RegWriteW && (hz.RdW != REG_ZERO) && (hz.RdW == hz.Rs1E)) begin
            fwd_a_s = 2'b01;
        end else begin
            fwd_a_s = 2'b00;
        end
        if (hz.RegWriteM && (hz.RdM != REG_ZERO) && (hz.RdM == hz.Rs2E)) begin
            fwd_b_s = 2'b10;
        end else if (hz.RegWriteW && (hz.RdW != REG_ZERO) && (hz.RdW == hz.Rs2E)) begin
            fwd_b_s = 2'b01;
        end else begin
            fwd_b_s = 2'b00;
        end
    end

    // Priority rules used whenever the sequencer is (or returns to) running.
    always_comb begin
        run_ctl_s = CTL_IDLE;
        if (hz.DmemBusyM) begin
            run_ctl_s = CTL_MEM_WAIT;
        end else if (hz.PCSrcE) begin
            run_ctl_s.flush_d     = 1'b1;
            run_ctl_s.flush_e     = 1'b1;
            run_ctl_s.fetch_abort = hz.ImemBusyF;
        end else if (lw_stall_s) begin
            run_ctl_s.stall_f = 1'b1;
            run_ctl_s.stall_d = 1'b1;
            run_ctl_s.flush_e = 1'b1;
        end else if (hz.ImemBusyF) begin
            run_ctl_s.stall_f = 1'b1;
            run_ctl_s.flush_d = 1'b1;
        end else begin
            run_ctl_s = CTL_IDLE;
        end
    end

    // Next-state and Mealy control decode.
    always_comb begin
        next_state_s = state_r;
        ctl_s        = run_ctl_s;
        case (state_r)
            ST_RUN: begin
                ctl_s = run_ctl_s;
                if (hz.DmemBusyM) begin
                    next_state_s = ST_MEM_WAIT;
                end else if (hz.PCSrcE || lw_stall_s) begin
                    next_state_s = ST_RUN;
                end else if (hz.ImemBusyF) begin
                    next_state_s = ST_FETCH_WAIT;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FETCH_WAIT: begin
                if (hz.DmemBusyM) begin
                    ctl_s        = CTL_MEM_WAIT;
                    next_state_s = ST_MEM_WAIT;
                end else if (hz.PCSrcE) begin
                    // A redirect kills the fetch still in flight, busy or not.
                    ctl_s             = CTL_IDLE;
                    ctl_s.fetch_abort = 1'b1;
                    ctl_s.flush_d     = 1'b1;
                    ctl_s.flush_e     = 1'b1;
                    next_state_s      = ST_RUN;
                end else if (hz.ImemBusyF) begin
                    ctl_s         = CTL_IDLE;
                    ctl_s.stall_f = 1'b1;
                    if (lw_stall_s) begin
                        ctl_s.stall_d = 1'b1;
                        ctl_s.flush_e = 1'b1;
                    end else begin
                        ctl_s.flush_d = 1'b1;
                    end
                    next_state_s = ST_FETCH_WAIT;
                end else begin
                    ctl_s        = run_ctl_s;
                    next_state_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.DmemBusyM) begin
                    ctl_s        = CTL_MEM_WAIT;
                    next_state_s = ST_MEM_WAIT;
                end else if (hz.ImemBusyF && !hz.PCSrcE) begin
                    ctl_s        = run_ctl_s;
                    next_state_s = ST_FETCH_WAIT;
                end else begin
                    ctl_s        = run_ctl_s;
                    next_state_s = ST_RUN;
                end
            end
            default: begin
                ctl_s        = CTL_IDLE;
                next_state_s = ST_RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait-cycle counter; the timeout flag latches on the MEM_TIMEOUT-th consecutive wait cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r    <= WAIT_ZERO;
            mem_timeout_r <= 1'b0;
        end else begin
            if (next_state_s == ST_RUN) begin
                wait_cnt_r <= WAIT_ZERO;
            end else if ((state_r != ST_RUN) && (wait_cnt_r != WAIT_MAX)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if ((state_r != ST_RUN) && (wait_cnt_r == WAIT_LAST)) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    // Reset forces bubbles into every register regardless of inputs.
    assign out_ctl_s     = rst_n ? ctl_s : CTL_RESET;
    assign hz.StallF     = out_ctl_s.stall_f;
    assign hz.StallD     = out_ctl_s.stall_d;
    assign hz.StallE     = out_ctl_s.stall_e;
    assign hz.StallM     = out_ctl_s.stall_m;
    assign hz.FlushD     = out_ctl_s.flush_d;
    assign hz.FlushE     = out_ctl_s.flush_e;
    assign hz.FlushW     = out_ctl_s.flush_w;
    assign hz.FetchAbort = out_ctl_s.fetch_abort;
    assign hz.ForwardAE  = rst_n ? fwd_a_s : 2'b00;
    assign hz.ForwardBE  = rst_n ? fwd_b_s : 2'b00;
    assign hz.MemTimeout = mem_timeout_r;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] stall_cycles_r;
    logic [CNT_WIDTH-1:0] flush_count_r;

    // Free-running, wrapping stall and flush event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= CNT_ZERO;
            flush_count_r  <= CNT_ZERO;
        end else begin
            if (ctl_s.stall_f) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (ctl_s.flush_d || ctl_s.flush_e) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign hz.StallCycles = stall_cycles_r;
    assign hz.FlushCount  = flush_count_r;
`else
    assign hz.StallCycles = {CNT_WIDTH{1'b0}};
    assign hz.FlushCount  = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a rule-level behavioural model.
module tb_hazard_ctrl;

    localparam int RAW = 5;
    localparam int MT  = 64;
    localparam int CW  = 32;

    localparam logic [7:0] SF = 8'h80, SD = 8'h40, SE = 8'h20, SM = 8'h10;
    localparam logic [7:0] FD = 8'h08, FE = 8'h04, FW = 8'h02, FA = 8'h01;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) hz_if ();

    hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: mode 0 = running, 1 = waiting on fetch, 2 = waiting on data memory.
    int          m_mode;
    int          m_wait;
    bit          m_tmo;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit load_use();
        return hz_if.ResultSrcE0 && hz_if.RdE != 5'd0 &&
               (hz_if.RdE == hz_if.Rs1D || hz_if.RdE == hz_if.Rs2D);
    endfunction

    function automatic logic [1:0] fwd(input logic [RAW-1:0] src);
        if (!rst_n) return 2'b00;
        if (hz_if.RegWriteM && hz_if.RdM != 5'd0 && hz_if.RdM == src) return 2'b10;
        if (hz_if.RegWriteW && hz_if.RdW != 5'd0 && hz_if.RdW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] running_rules();
        if (hz_if.DmemBusyM) return SF | SD | SE | SM | FW;
        if (hz_if.PCSrcE)    return FD | FE | (hz_if.ImemBusyF ? FA : 8'h00);
        if (load_use())      return SF | SD | FE;
        if (hz_if.ImemBusyF) return SF | FD;
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_ctl();
        if (!rst_n) return FD | FE | FW;
        if (m_mode == 1) begin
            if (hz_if.DmemBusyM) return SF | SD | SE | SM | FW;
            if (hz_if.PCSrcE)    return FA | FD | FE;
            if (hz_if.ImemBusyF) return load_use() ? (SF | SD | FE) : (SF | FD);
            return running_rules();
        end
        if (m_mode == 2 && hz_if.DmemBusyM) return SF | SD | SE | SM | FW;
        return running_rules();
    endfunction

    function automatic int next_mode();
        if (hz_if.DmemBusyM) return 2;
        if (m_mode == 0) return (!hz_if.PCSrcE && !load_use() && hz_if.ImemBusyF) ? 1 : 0;
        if (m_mode == 1) return (!hz_if.PCSrcE && hz_if.ImemBusyF) ? 1 : 0;
        return (hz_if.ImemBusyF && !hz_if.PCSrcE) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_wait  = 0;
        m_tmo   = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic model_edge();
        logic [7:0] e;
        int nm;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e  = exp_ctl();
        nm = next_mode();
        if (m_mode != 0) begin
            m_wait++;
            if (m_wait >= MT) m_tmo = 1'b1;
        end
        if (nm == 0) m_wait = 0;
        if (e[7]) m_stall++;
        if (e[3] || e[2]) m_flush++;
        m_mode = nm;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        hz_if.Rs1D = 5'd0; hz_if.Rs2D = 5'd0; hz_if.Rs1E = 5'd0; hz_if.Rs2E = 5'd0;
        hz_if.RdE  = 5'd0; hz_if.RdM  = 5'd0; hz_if.RdW  = 5'd0;
        hz_if.ResultSrcE0 = 1'b0; hz_if.RegWriteM = 1'b0; hz_if.RegWriteW = 1'b0;
        hz_if.PCSrcE = 1'b0; hz_if.ImemBusyF = 1'b0; hz_if.DmemBusyM = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        repeat (cycles) next_cycle();
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        logic [7:0] e;
        if (chk_en) begin
            e = exp_ctl();
            check("StallF", hz_if.StallF, e[7]);
            check("StallD", hz_if.StallD, e[6]);
            check("StallE", hz_if.StallE, e[5]);
            check("StallM", hz_if.StallM, e[4]);
            check("FlushD", hz_if.FlushD, e[3]);
            check("FlushE", hz_if.FlushE, e[2]);
            check("FlushW", hz_if.FlushW, e[1]);
            check("FetchAbort", hz_if.FetchAbort, e[0]);
            check("ForwardAE", hz_if.ForwardAE, fwd(hz_if.Rs1E));
            check("ForwardBE", hz_if.ForwardBE, fwd(hz_if.Rs2E));
            check("MemTimeout", hz_if.MemTimeout, m_tmo);
`ifdef HAZARD_PERF_EN
            check("StallCycles", hz_if.StallCycles, m_stall);
            check("FlushCount", hz_if.FlushCount, m_flush);
`else
            check("StallCycles", hz_if.StallCycles, 64'd0);
            check("FlushCount", hz_if.FlushCount, 64'd0);
`endif
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Reset held three cycles, then release into RUN.
        for (int i = 0; i < 3; i++) begin
            #5;
            check("rst_FlushD", hz_if.FlushD, 1'b1);
            check("rst_FlushW", hz_if.FlushW, 1'b1);
            check("rst_StallF", hz_if.StallF, 1'b0);
            next_cycle();
        end
        rst_n = 1'b1;
        #5;
        check("rel_MemTimeout", hz_if.MemTimeout, 1'b0);
        check("rel_FlushD", hz_if.FlushD, 1'b0);
        next_cycle();

        // Load-use stall, then the same with a taken branch.
        idle();
        hz_if.ResultSrcE0 = 1'b1; hz_if.RdE = 5'd5; hz_if.Rs1D = 5'd5;
        #5;
        check("lw_StallF", hz_if.StallF, 1'b1);
        check("lw_StallD", hz_if.StallD, 1'b1);
        check("lw_FlushE", hz_if.FlushE, 1'b1);
        check("lw_FlushD", hz_if.FlushD, 1'b0);
        next_cycle();
        hz_if.PCSrcE = 1'b1;
        #5;
        check("lwbr_StallD", hz_if.StallD, 1'b0);
        check("lwbr_FlushD", hz_if.FlushD, 1'b1);
        check("lwbr_FlushE", hz_if.FlushE, 1'b1);
        next_cycle();

        // Forwarding priority and x0 exclusion.
        idle();
        hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd7; hz_if.RegWriteW = 1'b1; hz_if.RdW = 5'd7;
        hz_if.Rs1E = 5'd7; hz_if.Rs2E = 5'd3;
        #5;
        check("fwd_M", hz_if.ForwardAE, 2'b10);
        check("fwd_B_none", hz_if.ForwardBE, 2'b00);
        next_cycle();
        hz_if.RdM = 5'd0;
        #5;
        check("fwd_W", hz_if.ForwardAE, 2'b01);
        next_cycle();

        // Data wait with a branch frozen in E.
        idle();
        hz_if.DmemBusyM = 1'b1; hz_if.PCSrcE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #5;
            check("mw_StallM", hz_if.StallM, 1'b1);
            check("mw_FlushW", hz_if.FlushW, 1'b1);
            check("mw_FlushD", hz_if.FlushD, 1'b0);
            next_cycle();
        end
        hz_if.DmemBusyM = 1'b0;
        #5;
        check("mwrel_FlushD", hz_if.FlushD, 1'b1);
        check("mwrel_FlushE", hz_if.FlushE, 1'b1);
        check("mwrel_StallF", hz_if.StallF, 1'b0);
        next_cycle();
        idle();
        #5;
        check("mwrun_StallF", hz_if.StallF, 1'b0);
        next_cycle();

        // Fetch wait cancelled by a branch.
        idle();
        hz_if.ImemBusyF = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #5;
            check("fw_StallF", hz_if.StallF, 1'b1);
            check("fw_FlushD", hz_if.FlushD, 1'b1);
            next_cycle();
        end
        hz_if.ImemBusyF = 1'b0; hz_if.PCSrcE = 1'b1;
        #5;
        check("fw_FetchAbort", hz_if.FetchAbort, 1'b1);
        check("fw_br_StallF", hz_if.StallF, 1'b0);
        next_cycle();
        idle();
        #5;
        check("fw_run_FetchAbort", hz_if.FetchAbort, 1'b0);
        next_cycle();

        // Long data wait trips the sticky timeout.
        do_reset(2);
        idle();
        next_cycle();
        hz_if.DmemBusyM = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            #5;
            if (i == 60) check("tmo_early", hz_if.MemTimeout, 1'b0);
            next_cycle();
        end
        hz_if.DmemBusyM = 1'b0;
        #5;
        check("tmo_set", hz_if.MemTimeout, 1'b1);
`ifdef HAZARD_PERF_EN
        check("tmo_StallCycles", hz_if.StallCycles, 64'd70);
`else
        check("tmo_StallCycles", hz_if.StallCycles, 64'd0);
`endif
        next_cycle();
        #5;
        check("tmo_sticky", hz_if.MemTimeout, 1'b1);
        next_cycle();
        do_reset(1);
        #5;
        check("tmo_cleared", hz_if.MemTimeout, 1'b0);
        next_cycle();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            hz_if.Rs1D = 5'($urandom_range(0, 3));
            hz_if.Rs2D = 5'($urandom_range(0, 3));
            hz_if.Rs1E = 5'($urandom_range(0, 3));
            hz_if.Rs2E = 5'($urandom_range(0, 3));
            hz_if.RdE  = 5'($urandom_range(0, 3));
            hz_if.RdM  = 5'($urandom_range(0, 3));
            hz_if.RdW  = 5'($urandom_range(0, 3));
            hz_if.ResultSrcE0 = ($urandom_range(0, 99) < 30);
            hz_if.RegWriteM   = ($urandom_range(0, 99) < 60);
            hz_if.RegWriteW   = ($urandom_range(0, 99) < 60);
            hz_if.PCSrcE      = ($urandom_range(0, 99) < 15);
            hz_if.ImemBusyF   = ($urandom_range(0, 99) < 35);
            hz_if.DmemBusyM   = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            next_cycle();
        end

        chk_en = 1'b0;
        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
